// File: rtl/iic_s.sv
// I2C slave: filtered SCL/SDA decode, 7-bit address match, register pointer,
// write strobes and request/data read port with pointer auto-increment.
module iic_s #(
  parameter logic [6:0] DEVICE_ADDR    = 7'h03,
  parameter int         REG_ADDR_BYTES = 2,
  parameter int         FILTER_LEN     = 3
) (
  input  logic        sysclk,
  input  logic        rstn,
  input  logic        iic_scl,
  inout  wire         iic_sda,
  output logic        slv_busy,
  output logic [15:0] slv_reg_addr,
  output logic [7:0]  slv_wr_data,
  output logic        slv_wr_valid,
  output logic        slv_rd_req,
  input  logic [7:0]  slv_rd_data,
  output logic        slv_done
);

  localparam int PW = 8 * REG_ADDR_BYTES;
  localparam int FW = $clog2(FILTER_LEN + 1);

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK,
    WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    scl_s_q, sda_s_q;
  logic          scl_f_q, scl_f_d, sda_f_q, sda_f_d;
  logic [FW-1:0] scl_cnt_q, scl_cnt_d, sda_cnt_q, sda_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          byte_idx_q, byte_idx_d;
  logic [PW-1:0] reg_sh_q, reg_sh_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [7:0]    rd_byte_q, rd_byte_d;
  logic          rd_ack_q, rd_ack_d;
  logic          rw_q, rw_d;
  logic          matched_q, matched_d;
  logic          sda_oe_q, sda_oe_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          wr_valid_q, wr_valid_d;
  logic          rd_req_q, rd_req_d;
  logic          done_q, done_d;

  logic          scl_rise, scl_fall, sda_rise, sda_fall, start_det, stop_det;
  logic [7:0]    rx_byte;
  logic          last_reg_byte;

  // Glitch filter: a new level is accepted only after FILTER_LEN consecutive
  // cycles of disagreement with the current filtered level.
  always_comb begin
    scl_cnt_d = '0;
    scl_f_d   = scl_f_q;
    if (scl_s_q[1] != scl_f_q) begin
      if (scl_cnt_q == FW'(FILTER_LEN - 1)) scl_f_d = scl_s_q[1];
      else                                  scl_cnt_d = scl_cnt_q + FW'(1);
    end
    sda_cnt_d = '0;
    sda_f_d   = sda_f_q;
    if (sda_s_q[1] != sda_f_q) begin
      if (sda_cnt_q == FW'(FILTER_LEN - 1)) sda_f_d = sda_s_q[1];
      else                                  sda_cnt_d = sda_cnt_q + FW'(1);
    end
  end

  assign scl_rise  =  scl_f_d & ~scl_f_q;
  assign scl_fall  = ~scl_f_d &  scl_f_q;
  assign sda_rise  =  sda_f_d & ~sda_f_q;
  assign sda_fall  = ~sda_f_d &  sda_f_q;
  assign start_det = sda_fall & scl_f_q;
  assign stop_det  = sda_rise & scl_f_q;
  assign last_reg_byte = (byte_idx_q == 1'(REG_ADDR_BYTES - 1));

  always_ff @(posedge sysclk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      scl_s_q    <= 2'b11;
      sda_s_q    <= 2'b11;
      scl_f_q    <= 1'b1;
      sda_f_q    <= 1'b1;
      scl_cnt_q  <= '0;
      sda_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      byte_idx_q <= 1'b0;
      reg_sh_q   <= '0;
      ptr_q      <= '0;
      rd_byte_q  <= '0;
      rd_ack_q   <= 1'b0;
      rw_q       <= 1'b0;
      matched_q  <= 1'b0;
      sda_oe_q   <= 1'b0;
      wr_data_q  <= '0;
      wr_valid_q <= 1'b0;
      rd_req_q   <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      scl_s_q    <= {scl_s_q[0], iic_scl};
      sda_s_q    <= {sda_s_q[0], iic_sda};
      scl_f_q    <= scl_f_d;
      sda_f_q    <= sda_f_d;
      scl_cnt_q  <= scl_cnt_d;
      sda_cnt_q  <= sda_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      byte_idx_q <= byte_idx_d;
      reg_sh_q   <= reg_sh_d;
      ptr_q      <= ptr_d;
      rd_byte_q  <= rd_byte_d;
      rd_ack_q   <= rd_ack_d;
      rw_q       <= rw_d;
      matched_q  <= matched_d;
      sda_oe_q   <= sda_oe_d;
      wr_data_q  <= wr_data_d;
      wr_valid_q <= wr_valid_d;
      rd_req_q   <= rd_req_d;
      done_q     <= done_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    byte_idx_d = byte_idx_q;
    reg_sh_d   = reg_sh_q;
    ptr_d      = ptr_q;
    rd_byte_d  = rd_byte_q;
    rd_ack_d   = rd_ack_q;
    rw_d       = rw_q;
    matched_d  = matched_q;
    sda_oe_d   = sda_oe_q;
    wr_data_d  = wr_data_q;
    wr_valid_d = 1'b0;
    rd_req_d   = 1'b0;
    done_d     = 1'b0;
    rx_byte    = {shift_q[6:0], sda_f_q};

    if (wr_valid_q) ptr_d = ptr_q + PW'(1);
    if (rd_req_q)   rd_byte_d = slv_rd_data;

    if (stop_det) begin
      state_d   = IDLE;
      sda_oe_d  = 1'b0;
      done_d    = matched_q;
      matched_d = 1'b0;
    end else if (start_det) begin
      state_d   = DEV_ADDR;
      sda_oe_d  = 1'b0;
      bit_cnt_d = '0;
      rd_ack_d  = 1'b0;
    end else begin
      case (state_q)
        DEV_ADDR: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (rx_byte[7:1] == DEVICE_ADDR && rx_byte[7:1] != 7'h00) begin
              state_d   = DEV_ACK;
              rw_d      = rx_byte[0];
              matched_d = 1'b1;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        // sda_oe_q doubles as the phase flag: first fall drives ACK, second ends it.
        DEV_ACK: begin
          if (scl_fall) begin
            if (!sda_oe_q) begin
              sda_oe_d = 1'b1;
            end else if (rw_q) begin
              sda_oe_d  = ~rd_byte_q[7];
              rd_byte_d = {rd_byte_q[6:0], 1'b0};
              bit_cnt_d = '0;
              state_d   = RD_DATA;
            end else begin
              sda_oe_d   = 1'b0;
              bit_cnt_d  = '0;
              byte_idx_d = 1'b0;
              state_d    = REG_ADDR;
            end
          end else if (scl_rise && rw_q) begin
            rd_req_d = 1'b1;
          end
        end
        REG_ADDR: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            reg_sh_d = PW'({reg_sh_q, rx_byte});
            if (last_reg_byte) ptr_d = PW'({reg_sh_q, rx_byte});
            state_d = REG_ACK;
          end
        end
        REG_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d  = 1'b0;
            bit_cnt_d = '0;
            if (last_reg_byte) begin
              state_d = WR_DATA;
            end else begin
              byte_idx_d = 1'b1;
              state_d    = REG_ADDR;
            end
          end
        end
        WR_DATA: if (scl_rise) begin
          shift_d   = rx_byte;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            wr_data_d = rx_byte;
            state_d   = WR_ACK;
          end
        end
        WR_ACK: if (scl_fall) begin
          if (!sda_oe_q) begin
            sda_oe_d = 1'b1;
          end else begin
            sda_oe_d   = 1'b0;
            wr_valid_d = 1'b1;
            bit_cnt_d  = '0;
            state_d    = WR_DATA;
          end
        end
        RD_DATA: if (scl_fall) begin
          if (bit_cnt_q == 3'd7) begin
            sda_oe_d = 1'b0;
            rd_ack_d = 1'b0;
            state_d  = RD_ACK;
          end else begin
            sda_oe_d  = ~rd_byte_q[7];
            rd_byte_d = {rd_byte_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
        // rd_ack_q: master ACK seen, waiting for the fall that starts the next byte.
        RD_ACK: begin
          if (!rd_ack_q && scl_rise) begin
            ptr_d = ptr_q + PW'(1);
            if (!sda_f_q) begin
              rd_req_d = 1'b1;
              rd_ack_d = 1'b1;
            end else begin
              state_d = IGNORE;
            end
          end else if (rd_ack_q && scl_fall) begin
            sda_oe_d  = ~rd_byte_q[7];
            rd_byte_d = {rd_byte_q[6:0], 1'b0};
            bit_cnt_d = '0;
            rd_ack_d  = 1'b0;
            state_d   = RD_DATA;
          end
        end
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (state_q)
      DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK: slv_busy = 1'b1;
      default:                                                     slv_busy = 1'b0;
    endcase
  end

  assign slv_reg_addr = 16'(ptr_q);
  assign slv_wr_data  = wr_data_q;
  assign slv_wr_valid = wr_valid_q;
  assign slv_rd_req   = rd_req_q;
  assign slv_done     = done_q;
  assign iic_sda      = sda_oe_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_iic_s.sv
// Directed bench for iic_s: a bit-banged I2C master drives the bus, a
// scoreboard collects write strobes and compares them with hand-computed values.
module tb_iic_s;

  localparam int Q = 10;

  logic        sysclk = 1'b0;
  logic        rstn = 1'b0;
  logic        iic_scl = 1'b1;
  logic        m_sda_oe = 1'b0;
  wire         iic_sda;
  logic        slv_busy;
  logic [15:0] slv_reg_addr;
  logic [7:0]  slv_wr_data;
  logic        slv_wr_valid;
  logic        slv_rd_req;
  logic [7:0]  slv_rd_data = 8'hA5;
  logic        slv_done;

  int n_errors = 0;
  int n_checks = 0;
  int done_n = 0;
  int rd_req_n = 0;
  logic [15:0] rd_req_addr = '0;
  logic [23:0] exp_q[$];
  logic [23:0] got_q[$];

  int   done_base, rd_base;
  logic a;
  logic r;
  logic [7:0] d;

  assign iic_sda = m_sda_oe ? 1'b0 : 1'bz;
  pullup (iic_sda);

  always #5 sysclk = ~sysclk;

  iic_s dut (
    .sysclk       (sysclk),
    .rstn         (rstn),
    .iic_scl      (iic_scl),
    .iic_sda      (iic_sda),
    .slv_busy     (slv_busy),
    .slv_reg_addr (slv_reg_addr),
    .slv_wr_data  (slv_wr_data),
    .slv_wr_valid (slv_wr_valid),
    .slv_rd_req   (slv_rd_req),
    .slv_rd_data  (slv_rd_data),
    .slv_done     (slv_done)
  );

  always @(negedge sysclk) begin
    if (slv_wr_valid) got_q.push_back({slv_reg_addr, slv_wr_data});
    if (slv_rd_req) begin
      rd_req_n++;
      rd_req_addr = slv_reg_addr;
    end
    if (slv_done) done_n++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge sysclk);
  endtask

  task automatic m_start();
    m_sda_oe = 1'b0;
    wait_q();
    iic_scl = 1'b1;
    wait_q();
    m_sda_oe = 1'b1;
    wait_q();
    iic_scl = 1'b0;
  endtask

  task automatic m_stop();
    wait_q();
    m_sda_oe = 1'b1;
    wait_q();
    iic_scl = 1'b1;
    wait_q();
    m_sda_oe = 1'b0;
    wait_q();
  endtask

  // A glitch inverts the master's SDA for one sysclk during SCL high.
  task automatic m_bit(input logic b, input logic glitch, output logic rb);
    wait_q();
    m_sda_oe = ~b;
    wait_q();
    iic_scl = 1'b1;
    wait_q();
    rb = iic_sda;
    if (glitch) begin
      m_sda_oe = ~m_sda_oe;
      @(negedge sysclk);
      m_sda_oe = ~m_sda_oe;
    end
    wait_q();
    iic_scl = 1'b0;
  endtask

  task automatic m_write_byte(input logic [7:0] wd, input logic [7:0] gmask, output logic ack_bit);
    logic rb;
    for (int i = 7; i >= 0; i--) m_bit(wd[i], gmask[i], rb);
    m_bit(1'b1, 1'b0, ack_bit);
  endtask

  task automatic m_read_byte(input logic nack, output logic [7:0] rd);
    logic rb;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, 1'b0, rb);
      rd[i] = rb;
    end
    m_bit(nack, 1'b0, rb);
  endtask

  task automatic m_addr_reg(input string tag, input logic [15:0] ra);
    logic ab;
    m_start();
    m_write_byte(8'h06, 8'h00, ab);
    check({tag, "_dev_ack"}, ab, 1'b0);
    check({tag, "_busy"}, slv_busy, 1'b1);
    m_write_byte(ra[15:8], 8'h00, ab);
    check({tag, "_rh_ack"}, ab, 1'b0);
    m_write_byte(ra[7:0], 8'h00, ab);
    check({tag, "_rl_ack"}, ab, 1'b0);
  endtask

  task automatic m_data(input string tag, input logic [7:0] wd, input logic [7:0] gmask);
    logic ab;
    m_write_byte(wd, gmask, ab);
    check({tag, "_data_ack"}, ab, 1'b0);
  endtask

  task automatic sb_check(input string tag);
    check({tag, "_nstrobes"}, got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      check({tag, "_strobe"}, got_q.pop_front(), exp_q.pop_front());
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    // Reset state
    repeat (5) @(negedge sysclk);
    check("rst_flags", {slv_busy, slv_wr_valid, slv_rd_req, slv_done}, 4'b0000);
    check("rst_addr", slv_reg_addr, 16'h0000);
    check("rst_wdata", slv_wr_data, 8'h00);
    check("rst_sda", iic_sda, 1'b1);
    rstn = 1'b1;
    repeat (5) @(negedge sysclk);

    // 1: three-byte write from register 0x0001
    done_base = done_n;
    m_addr_reg("t1", 16'h0001);
    m_data("t1", 8'h11, 8'h00);
    m_data("t1", 8'h22, 8'h00);
    m_data("t1", 8'h33, 8'h00);
    m_stop();
    repeat (10) @(negedge sysclk);
    exp_q.push_back({16'h0001, 8'h11});
    exp_q.push_back({16'h0002, 8'h22});
    exp_q.push_back({16'h0003, 8'h33});
    sb_check("t1");
    check("t1_done", done_n - done_base, 1);
    check("t1_busy_end", slv_busy, 1'b0);
    check("t1_ptr", slv_reg_addr, 16'h0004);

    // 2: set pointer, repeated START, read one byte, NACK
    done_base = done_n;
    rd_base = rd_req_n;
    m_addr_reg("t2", 16'h0001);
    m_start();
    m_write_byte(8'h07, 8'h00, a);
    check("t2_rd_ack", a, 1'b0);
    m_read_byte(1'b1, d);
    check("t2_rdata", d, 8'hA5);
    check("t2_rdreq_n", rd_req_n - rd_base, 1);
    check("t2_rdreq_addr", rd_req_addr, 16'h0001);
    check("t2_ptr", slv_reg_addr, 16'h0002);
    m_stop();
    repeat (10) @(negedge sysclk);
    sb_check("t2");
    check("t2_done", done_n - done_base, 1);

    // 3: wrong device address is not acknowledged
    done_base = done_n;
    m_start();
    m_write_byte(8'h0A, 8'h00, a);
    check("t3_nack", a, 1'b1);
    check("t3_busy", slv_busy, 1'b0);
    m_stop();
    repeat (10) @(negedge sysclk);
    sb_check("t3");
    check("t3_done", done_n - done_base, 0);

    // 4: pointer wraps from 0xFFFF to 0x0000
    m_addr_reg("t4", 16'hFFFF);
    m_data("t4", 8'hAA, 8'h00);
    m_data("t4", 8'hBB, 8'h00);
    m_stop();
    repeat (10) @(negedge sysclk);
    exp_q.push_back({16'hFFFF, 8'hAA});
    exp_q.push_back({16'h0000, 8'hBB});
    sb_check("t4");
    check("t4_ptr", slv_reg_addr, 16'h0001);

    // 5: STOP after a partial byte, then 1-cycle SDA glitches during SCL high
    done_base = done_n;
    m_addr_reg("t5", 16'h0010);
    for (int i = 0; i < 4; i++) m_bit(i[0], 1'b0, r);
    m_stop();
    repeat (10) @(negedge sysclk);
    sb_check("t5");
    check("t5_busy", slv_busy, 1'b0);
    check("t5_sda", iic_sda, 1'b1);
    check("t5_done", done_n - done_base, 1);
    m_addr_reg("t5g", 16'h0020);
    m_data("t5g", 8'h5A, 8'hC0);
    m_stop();
    repeat (10) @(negedge sysclk);
    exp_q.push_back({16'h0020, 8'h5A});
    sb_check("t5g");

    // 6: reset while the slave drives a '0' read bit
    slv_rd_data = 8'h3C;
    m_addr_reg("t6", 16'h0030);
    m_start();
    m_write_byte(8'h07, 8'h00, a);
    check("t6_rd_ack", a, 1'b0);
    wait_q();
    check("t6_drive", iic_sda, 1'b0);
    rstn = 1'b0;
    @(posedge sysclk);
    #1;
    check("t6_rst_sda", iic_sda, 1'b1);
    check("t6_rst_flags", {slv_busy, slv_wr_valid, slv_rd_req, slv_done}, 4'b0000);
    check("t6_rst_addr", slv_reg_addr, 16'h0000);
    check("t6_rst_wdata", slv_wr_data, 8'h00);
    repeat (3) @(negedge sysclk);
    rstn = 1'b1;
    repeat (5) @(negedge sysclk);
    m_stop();
    repeat (10) @(negedge sysclk);
    got_q.delete();
    done_base = done_n;
    m_addr_reg("t6w", 16'h0042);
    m_data("t6w", 8'h77, 8'h00);
    m_stop();
    repeat (10) @(negedge sysclk);
    exp_q.push_back({16'h0042, 8'h77});
    sb_check("t6w");
    check("t6w_done", done_n - done_base, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
